onchip_mem_block_master: RTL and testbench
==========================================

Name: onchip_mem_block_master

Overview:
- Avalon-MM initiator that drives the single-port on-chip RAM slave: 16-bit word address, 32-bit data, byteenable, chipselect/write, no waitrequest, fixed read latency.
- Accepts one block command (start address, length, direction) and moves data between streaming ports and the RAM.
- Used by test/boot logic to preload or dump on-chip memory without the Nios II core.

Parameters:
- ADDR_W, 16, word address width.
- DATA_W, 32, data width; byteenable width = DATA_W/8.
- MEM_DEPTH, 51200, words in target RAM; address wrap point.
- READ_LATENCY, 1, cycles from read issue to valid avm_readdata (registered address, unregistered output).
- FIFO_DEPTH, 4, read return buffer depth; must be ≥ READ_LATENCY+1, power of two.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  high only in IDLE
- cmd_write  in  1  1 = stream→RAM, 0 = RAM→stream
- cmd_addr  in  ADDR_W  start word address (< MEM_DEPTH)
- cmd_len  in  16  word count; 0 allowed
- wr_data  in  DATA_W  write beat
- wr_valid  in  1  write beat offered
- wr_ready  out  1  write beat accepted
- rd_data  out  DATA_W  read beat (FIFO head)
- rd_valid  out  1  FIFO non-empty
- rd_ready  in  1  consumer accepts beat
- busy  out  1  state ≠ IDLE
- done  out  1  one-cycle pulse at command completion
- avm_address  out  ADDR_W  RAM word address
- avm_byteenable  out  DATA_W/8  always all ones
- avm_chipselect  out  1  access strobe
- avm_write  out  1  write strobe
- avm_writedata  out  DATA_W  = wr_data
- avm_readdata  in  DATA_W  RAM read data
- avm_clken  out  1  RAM clock enable
- avm_reset_req  out  1  held 0

Behaviour:
- Reset (async, reset_n low): state IDLE; cmd_ready=1 after release; busy=0, done=0, wr_ready=0, rd_valid=0, avm_chipselect=0, avm_write=0, avm_address=0, avm_clken=1, avm_reset_req=0; FIFO emptied, in-flight pipe cleared. Reset mid-command aborts it: no done, partial data discarded.
- States: IDLE, WRITE, READ, DRAIN, DONE.
- IDLE: cmd_valid&cmd_ready latches addr/len/dir. len=0 → DONE. cmd_write=1 → WRITE. Otherwise → READ.
- WRITE: wr_ready=1 while remaining>0, combinational. Beat accepted when wr_valid&wr_ready. Same cycle: avm_chipselect=avm_write=1, avm_address=current addr. Then addr advances and remaining decrements. When remaining reaches 0 → DONE. Gaps in wr_valid produce idle bus cycles.
- READ: issue a read (chipselect=1, write=0) when remaining>0 and fifo_count+inflight < FIFO_DEPTH. The in-flight shift register (READ_LATENCY deep) captures avm_readdata into the FIFO exactly READ_LATENCY cycles after issue. The last issue moves to DRAIN.
- DRAIN: wait until inflight=0 and FIFO empty, then DONE.
- DONE: done=1 for one cycle, then IDLE. busy=0 only in IDLE.
- Address wrap: MEM_DEPTH-1 increments to 0, with no gap.
- FIFO: simultaneous push and pop keeps the count. rd_data is stable while rd_valid&!rd_ready. Per-cycle issue plus per-cycle pop gives full throughput, 1 word/cycle.
- cmd_valid outside IDLE is ignored. wr_valid outside WRITE is ignored (wr_ready=0).
- Counters are 16-bit, and remaining never underflows.

Decomposition:
- Package onchip_mem_pkg holds ADDR_W/DATA_W defaults, MEM_DEPTH constant, and the state enum type.
- Sub-module onchip_mem_rd_fifo: synchronous FIFO with count output, async active-low reset, parameterised depth/width.

Test Plan:
- Write addr=0x0010, len=4, data 0xA0..0xA3, wr_valid continuous → avm_write on 4 consecutive cycles at 0x10..0x13, done one cycle after the last beat; a RAM model holds the values.
- Read back addr=0x0010, len=4, rd_ready=1 → rd_data 0xA0..0xA3 back-to-back, first beat READ_LATENCY+1 cycles after command, then done.
- Read addr=51198, len=4 → avm_address sequence 51198, 51199, 0, 1; data in that order.
- Read len=8 with rd_ready toggling 1/0 → no loss or duplication, fifo_count never exceeds FIFO_DEPTH, rd_data held while stalled.
- Command len=0 → no chipselect, done pulse, back in IDLE within 2 cycles; a second cmd_valid while busy is not accepted.
- Assert reset_n low mid-read after 2 of 6 beats → all outputs at reset values immediately, rd_valid=0, no done; a new command afterwards completes normally.

Source files
------------

// File: rtl/onchip_mem_pkg.sv
// rtl/onchip_mem_pkg.sv - shared constants and FSM state type for the on-chip RAM block master
//
// Purpose: default widths, target RAM depth and the controller state enum,
//          imported by the block master top.
package onchip_mem_pkg;

  localparam int ADDR_W_DEF    = 16;
  localparam int DATA_W_DEF    = 32;
  localparam int MEM_DEPTH_DEF = 51200;
  localparam int LEN_W         = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WRITE,
    ST_READ,
    ST_DRAIN,
    ST_DONE
  } state_e;

endpackage

// File: rtl/onchip_mem_rd_fifo.sv
// rtl/onchip_mem_rd_fifo.sv - synchronous read-return FIFO with occupancy count
//
// Purpose: buffers RAM read data until the stream consumer takes it.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset (empties the FIFO)
//   push_i        write push_data_i (ignored when full and not popping)
//   pop_i         drop the head entry (ignored when empty)
//   pop_data_o    head entry, valid while empty_o is low
//   count_o       number of stored entries (0..DEPTH)
//   empty_o       no entries stored
module onchip_mem_rd_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         push_data_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         pop_data_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     empty_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             do_push;
  logic             do_pop;

  assign do_pop  = pop_i && (count_q != '0);
  // A full FIFO can still take a push in the same cycle its head is popped.
  assign do_push = push_i && ((count_q != CNT_W'(DEPTH)) || do_pop);

  // Pointers wrap naturally because DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      count_q <= count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_data_i;
  end

  assign pop_data_o = mem_q[rd_ptr_q];
  assign count_o    = count_q;
  assign empty_o    = (count_q == '0);

endmodule

// File: rtl/onchip_mem_block_master.sv
// rtl/onchip_mem_block_master.sv - block-transfer Avalon-MM initiator for the on-chip RAM
//
// Purpose: takes one command (start address, length, direction) and moves that
//          many words between the write/read streams and the single-port RAM.
// Ports:
//   clk, reset_n                        clock, asynchronous active-low reset
//   cmd_valid/cmd_ready/cmd_write/
//   cmd_addr/cmd_len                    block command (accepted only in IDLE)
//   wr_data/wr_valid/wr_ready           write stream (stream -> RAM)
//   rd_data/rd_valid/rd_ready           read stream (RAM -> stream), FIFO head
//   busy, done                          not-idle flag, one-cycle completion pulse
//   avm_*                               Avalon-MM master towards the RAM slave
module onchip_mem_block_master
  import onchip_mem_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MEM_DEPTH    = MEM_DEPTH_DEF,
  parameter int READ_LATENCY = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                cmd_valid,
  output logic                cmd_ready,
  input  logic                cmd_write,
  input  logic [ADDR_W-1:0]   cmd_addr,
  input  logic [LEN_W-1:0]    cmd_len,
  input  logic [DATA_W-1:0]   wr_data,
  input  logic                wr_valid,
  output logic                wr_ready,
  output logic [DATA_W-1:0]   rd_data,
  output logic                rd_valid,
  input  logic                rd_ready,
  output logic                busy,
  output logic                done,
  output logic [ADDR_W-1:0]   avm_address,
  output logic [DATA_W/8-1:0] avm_byteenable,
  output logic                avm_chipselect,
  output logic                avm_write,
  output logic [DATA_W-1:0]   avm_writedata,
  input  logic [DATA_W-1:0]   avm_readdata,
  output logic                avm_clken,
  output logic                avm_reset_req
);

  localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

  state_e                  state_q, state_d;
  logic [ADDR_W-1:0]       addr_q, addr_d;
  logic [LEN_W-1:0]        rem_q, rem_d;
  logic [READ_LATENCY-1:0] pipe_q, pipe_d;
  logic [ADDR_W-1:0]       addr_inc;
  logic [CNT_W-1:0]        fifo_count;
  logic [CNT_W-1:0]        inflight;
  logic                    fifo_empty;
  logic                    room;
  logic                    wr_beat;
  logic                    rd_issue;

  // Next word address, wrapping at the end of the RAM without a gap.
  assign addr_inc = (addr_q == ADDR_W'(MEM_DEPTH - 1)) ? '0 : addr_q + ADDR_W'(1);

  // Reads issued but not yet landed in the FIFO.
  always_comb begin
    inflight = '0;
    for (int i = 0; i < READ_LATENCY; i++) begin
      inflight = inflight + CNT_W'(pipe_q[i]);
    end
  end

  // Only issue when every outstanding read is guaranteed a FIFO slot.
  assign room = ({1'b0, fifo_count} + {1'b0, inflight}) < (CNT_W + 1)'(FIFO_DEPTH);

  always_comb begin
    state_d  = state_q;
    addr_d   = addr_q;
    rem_d    = rem_q;
    wr_ready = 1'b0;
    wr_beat  = 1'b0;
    rd_issue = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_valid) begin
          addr_d = cmd_addr;
          rem_d  = cmd_len;
          if (cmd_len == '0)  state_d = ST_DONE;
          else if (cmd_write) state_d = ST_WRITE;
          else                state_d = ST_READ;
        end
      end
      ST_WRITE: begin
        wr_ready = (rem_q != '0);
        wr_beat  = wr_valid && (rem_q != '0);
        if (wr_beat) begin
          addr_d = addr_inc;
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = ST_DONE;
        end
      end
      ST_READ: begin
        rd_issue = (rem_q != '0) && room;
        if (rd_issue) begin
          addr_d = addr_inc;
          rem_d  = rem_q - LEN_W'(1);
          if (rem_q == LEN_W'(1)) state_d = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if ((inflight == '0) && fifo_empty) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Oldest stage of the in-flight pipe marks the cycle avm_readdata is valid.
  assign pipe_d = (pipe_q << 1) | READ_LATENCY'(rd_issue);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      addr_q  <= '0;
      rem_q   <= '0;
      pipe_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      rem_q   <= rem_d;
      pipe_q  <= pipe_d;
    end
  end

  onchip_mem_rd_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (DATA_W)
  ) u_rd_fifo (
    .clk         (clk),
    .rst_n       (reset_n),
    .push_i      (pipe_q[READ_LATENCY-1]),
    .push_data_i (avm_readdata),
    .pop_i       (rd_valid && rd_ready),
    .pop_data_o  (rd_data),
    .count_o     (fifo_count),
    .empty_o     (fifo_empty)
  );

  assign rd_valid       = !fifo_empty;
  assign cmd_ready      = (state_q == ST_IDLE);
  assign busy           = (state_q != ST_IDLE);
  assign done           = (state_q == ST_DONE);
  assign avm_address    = addr_q;
  assign avm_chipselect = wr_beat || rd_issue;
  assign avm_write      = wr_beat;
  assign avm_writedata  = wr_data;
  assign avm_byteenable = '1;
  assign avm_clken      = 1'b1;
  assign avm_reset_req  = 1'b0;

endmodule

// File: tb/tb_onchip_mem_block_master.sv
// tb/tb_onchip_mem_block_master.sv - self-checking bench for onchip_mem_block_master
module tb_onchip_mem_block_master;

  localparam int MEM_DEPTH    = 51200;
  localparam int READ_LATENCY = 1;
  localparam int FIFO_DEPTH   = 4;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        cmd_valid, cmd_ready, cmd_write;
  logic [15:0] cmd_addr, cmd_len;
  logic [31:0] wr_data;
  logic        wr_valid, wr_ready;
  logic [31:0] rd_data;
  logic        rd_valid, rd_ready;
  logic        busy, done;
  logic [15:0] avm_address;
  logic [3:0]  avm_byteenable;
  logic        avm_chipselect, avm_write;
  logic [31:0] avm_writedata, avm_readdata;
  logic        avm_clken, avm_reset_req;

  onchip_mem_block_master dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .cmd_valid      (cmd_valid),
    .cmd_ready      (cmd_ready),
    .cmd_write      (cmd_write),
    .cmd_addr       (cmd_addr),
    .cmd_len        (cmd_len),
    .wr_data        (wr_data),
    .wr_valid       (wr_valid),
    .wr_ready       (wr_ready),
    .rd_data        (rd_data),
    .rd_valid       (rd_valid),
    .rd_ready       (rd_ready),
    .busy           (busy),
    .done           (done),
    .avm_address    (avm_address),
    .avm_byteenable (avm_byteenable),
    .avm_chipselect (avm_chipselect),
    .avm_write      (avm_write),
    .avm_writedata  (avm_writedata),
    .avm_readdata   (avm_readdata),
    .avm_clken      (avm_clken),
    .avm_reset_req  (avm_reset_req)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // RAM slave: registered read address, unregistered read data (latency 1).
  logic [31:0] ram     [MEM_DEPTH];
  logic [31:0] ref_mem [MEM_DEPTH];
  int          ram_raddr = 0;
  logic        load_ram = 1'b0;
  always @(posedge clk) begin
    if (load_ram) begin
      for (int i = 0; i < MEM_DEPTH; i++) ram[i] <= ref_mem[i];
    end else if (avm_chipselect && avm_write) begin
      ram[int'(avm_address)] <= avm_writedata;
    end
    if (avm_chipselect && !avm_write) ram_raddr <= int'(avm_address);
  end
  assign avm_readdata = ram[ram_raddr];

  int total = 0;
  int bad = 0;

  int acc_cnt, acc_cyc, done_cnt, done_cyc, issued, popped, wr_idx;
  bit hold_cmd, prev_stall, idle_after;
  logic [31:0] prev_data;
  int          bus_addr[$];
  int          bus_cyc[$];
  bit          bus_wr[$];
  logic [31:0] beat_data[$];
  int          beat_cyc[$];
  logic [31:0] wbeats[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One observation per cycle, on the falling edge.
  task automatic sample();
    @(negedge clk);
    chk("clken", avm_clken, 1);
    chk("reset_req", avm_reset_req, 0);
    chk("busy_vs_cmd_ready", busy, !cmd_ready);
    if (prev_stall) begin
      chk("rd_hold_valid", rd_valid, 1);
      chk("rd_hold_data", rd_data, prev_data);
    end
    if (cmd_valid && cmd_ready) begin
      acc_cnt++;
      acc_cyc = cyc;
    end
    if (!busy) begin
      chk("idle_wr_ready", wr_ready, 0);
      chk("idle_chipselect", avm_chipselect, 0);
    end
    if (avm_chipselect) begin
      chk("byteenable", avm_byteenable, 4'hF);
      bus_addr.push_back(int'(avm_address));
      bus_wr.push_back(avm_write);
      bus_cyc.push_back(cyc);
      if (avm_write) chk("write_without_beat", wr_valid && wr_ready, 1);
      else issued++;
    end
    if (wr_valid && wr_ready) begin
      chk("beat_without_write", avm_chipselect && avm_write, 1);
      wr_idx++;
    end
    if (rd_valid && rd_ready) begin
      beat_data.push_back(rd_data);
      beat_cyc.push_back(cyc);
      popped++;
    end
    chk("occupancy_le_depth", (issued - popped) <= FIFO_DEPTH, 1);
    prev_stall = rd_valid && !rd_ready;
    prev_data  = rd_data;
    if (done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  endtask

  task automatic drive_inputs(input int mode);
    cmd_valid = (acc_cnt == 0) || (hold_cmd && done_cnt == 0);
    wr_valid  = (mode == 0) ? 1'b1 : 1'($urandom);
    wr_data   = (wr_idx < wbeats.size()) ? wbeats[wr_idx] : $urandom;
    if (mode == 0)      rd_ready = 1'b1;
    else if (mode == 1) rd_ready = (cyc % 2 == 0);
    else                rd_ready = 1'($urandom);
  endtask

  // mode: 0 continuous, 1 rd_ready toggling, 2 random handshakes.
  task automatic run_cmd(input bit wr, input int addr, input int len, input int mode,
                         input bit hold, input int abort_after);
    bit finished;
    acc_cnt = 0; done_cnt = 0; issued = 0; popped = 0; wr_idx = 0;
    acc_cyc = 0; done_cyc = 0;
    prev_stall = 0; idle_after = 0; hold_cmd = hold; finished = 0;
    bus_addr.delete(); bus_cyc.delete(); bus_wr.delete();
    beat_data.delete(); beat_cyc.delete();
    @(posedge clk); #1;
    cmd_write = wr;
    cmd_addr  = 16'(addr);
    cmd_len   = 16'(len);
    drive_inputs(mode);
    for (int n = 0; n < 400; n++) begin
      sample();
      if (done_cnt > 0 || (abort_after > 0 && popped >= abort_after)) begin
        finished = 1;
        break;
      end
      @(posedge clk); #1;
      drive_inputs(mode);
    end
    chk("cmd_finished_in_budget", finished, 1);
    if (done_cnt > 0) begin
      @(posedge clk); #1;
      drive_inputs(mode);
      cmd_valid = 1'b0;
      sample();
      idle_after = cmd_ready && !busy;
    end
    cmd_valid = 1'b0;
  endtask

  task automatic check_cmd(input bit wr, input int addr, input int len);
    chk("accept_count", acc_cnt, 1);
    chk("done_count", done_cnt, 1);
    chk("idle_after_done", idle_after, 1);
    chk("bus_count", bus_addr.size(), len);
    for (int i = 0; i < len && i < bus_addr.size(); i++) begin
      chk("bus_addr", bus_addr[i], (addr + i) % MEM_DEPTH);
      chk("bus_dir", bus_wr[i], wr);
    end
    if (wr) begin
      for (int i = 0; i < len; i++) begin
        chk("ram_content", ram[(addr + i) % MEM_DEPTH], wbeats[i]);
        ref_mem[(addr + i) % MEM_DEPTH] = wbeats[i];
      end
    end else begin
      chk("beat_count", beat_data.size(), len);
      for (int i = 0; i < len && i < beat_data.size(); i++)
        chk("rd_data", beat_data[i], ref_mem[(addr + i) % MEM_DEPTH]);
    end
  endtask

  task automatic make_beats(input int len);
    wbeats.delete();
    for (int i = 0; i < len; i++) wbeats.push_back($urandom);
  endtask

  initial begin
    int a, l;
    bit w;
    reset_n = 1'b0; cmd_valid = 0; cmd_write = 0; cmd_addr = 0; cmd_len = 0;
    wr_data = 0; wr_valid = 0; rd_ready = 0;
    for (int i = 0; i < MEM_DEPTH; i++) ref_mem[i] = $urandom;
    load_ram = 1'b1;
    repeat (2) @(negedge clk);
    load_ram = 1'b0;
    @(negedge clk);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_wr_ready", wr_ready, 0);
    chk("rst_rd_valid", rd_valid, 0);
    chk("rst_cs", avm_chipselect, 0);
    chk("rst_write", avm_write, 0);
    chk("rst_addr", avm_address, 0);
    chk("rst_clken", avm_clken, 1);
    chk("rst_reset_req", avm_reset_req, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("cmd_ready_after_release", cmd_ready, 1);

    // Write 0xA0..0xA3 to 0x10 with continuous wr_valid.
    wbeats = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    run_cmd(1, 16'h0010, 4, 0, 0, 0);
    check_cmd(1, 16'h0010, 4);
    if (bus_cyc.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("wr_cycle", bus_cyc[i] - acc_cyc, i + 1);
      chk("wr_done_timing", done_cyc, bus_cyc[3] + 1);
    end

    // Read it back; counting from the edge that accepts the command.
    run_cmd(0, 16'h0010, 4, 0, 0, 0);
    check_cmd(0, 16'h0010, 4);
    if (beat_cyc.size() == 4) begin
      chk("rd_first_latency", beat_cyc[0] - acc_cyc, READ_LATENCY + 2);
      for (int i = 1; i < 4; i++) chk("rd_back_to_back", beat_cyc[i] - beat_cyc[0], i);
      chk("rd_done_after_beats", done_cyc > beat_cyc[3], 1);
    end

    // Wrap at the end of the RAM, write with gaps then read.
    make_beats(4);
    run_cmd(1, MEM_DEPTH - 2, 4, 2, 0, 0);
    check_cmd(1, MEM_DEPTH - 2, 4);
    run_cmd(0, MEM_DEPTH - 2, 4, 0, 0, 0);
    check_cmd(0, MEM_DEPTH - 2, 4);
    if (bus_cyc.size() == 4) chk("wrap_no_gap", bus_cyc[3] - bus_cyc[0], 3);

    // Read 8 with rd_ready toggling.
    a = $urandom_range(MEM_DEPTH - 1);
    run_cmd(0, a, 8, 1, 0, 0);
    check_cmd(0, a, 8);

    // Zero-length command with cmd_valid held high while busy.
    run_cmd(1, 16'h0123, 0, 0, 1, 0);
    check_cmd(1, 16'h0123, 0);
    chk("len0_done_timing", done_cyc - acc_cyc, 1);
    make_beats(3);
    run_cmd(1, 16'h0200, 3, 2, 1, 0);
    check_cmd(1, 16'h0200, 3);

    // Reset in the middle of a 6-word read, after 2 beats.
    a = $urandom_range(MEM_DEPTH - 1);
    run_cmd(0, a, 6, 0, 0, 2);
    chk("abort_beats_seen", popped, 2);
    #2 reset_n = 1'b0;
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_done", done, 0);
    chk("abort_rd_valid", rd_valid, 0);
    chk("abort_cs", avm_chipselect, 0);
    chk("abort_write", avm_write, 0);
    chk("abort_addr", avm_address, 0);
    chk("abort_wr_ready", wr_ready, 0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", done, 0);
      chk("abort_rd_valid_held", rd_valid, 0);
    end
    @(posedge clk); #1 reset_n = 1'b1;
    @(negedge clk);
    chk("abort_cmd_ready", cmd_ready, 1);
    a = $urandom_range(MEM_DEPTH - 1);
    make_beats(5);
    run_cmd(1, a, 5, 2, 0, 0);
    check_cmd(1, a, 5);
    run_cmd(0, a, 5, 2, 0, 0);
    check_cmd(0, a, 5);

    // Random commands, some straddling the wrap point.
    for (int k = 0; k < 12; k++) begin
      w = 1'($urandom);
      a = ($urandom % 2 == 1) ? $urandom_range(MEM_DEPTH - 1) : MEM_DEPTH - 1 - $urandom_range(3);
      l = $urandom_range(12);
      make_beats(l);
      run_cmd(w, a, l, 2, 1'($urandom), 0);
      check_cmd(w, a, l);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
